// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and single-byte access sequencer for the shared data RAM port.
// Optional port-1 write protection of [WP_LO, WP_HI] is enabled by defining MEM_ARB_WP_EN.
module mem_arbiter #(
  parameter logic [7:0] WP_LO = 8'h00,
  parameter logic [7:0] WP_HI = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_gnt,
  output logic       m0_done,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_gnt,
  output logic       m1_done,
  output logic [7:0] m1_rdata,
  output logic       m1_err,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       busy
);

`ifdef MEM_ARB_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  localparam logic [7:0] WP_SPAN = 8'(WP_HI - WP_LO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       blocked_q, blocked_d;
  logic       cmd_we_q, cmd_we_d;
  logic [7:0] cmd_addr_q, cmd_addr_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       ram_we_q, ram_we_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic       win;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic [7:0] wp_off;
  logic       wp_hit;

  // Winner selection: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    win       = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    wp_off    = 8'(sel_addr - WP_LO);
    wp_hit    = WP_EN & win & sel_we & (wp_off <= WP_SPAN);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    blocked_d   = blocked_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ram_we_d    = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d     = S_ACCESS;
          owner_d     = win;
          last_d      = win;
          cmd_we_d    = sel_we;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          blocked_d   = wp_hit;
          ram_we_d    = sel_we & ~wp_hit;
          gnt0_d      = ~win;
          gnt1_d      = win;
          busy_d      = 1'b1;
        end
      end
      S_ACCESS: begin
        // Capture happens on writes too, returning the pre-write byte.
        state_d = S_DONE;
        if (owner_q) rdata1_d = ram_rdata;
        else         rdata0_d = ram_rdata;
        done0_d = ~owner_q;
        done1_d = owner_q;
        err_d   = owner_q & blocked_q;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      blocked_q   <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 8'h00;
      cmd_wdata_q <= 8'h00;
      rdata0_q    <= 8'h00;
      rdata1_q    <= 8'h00;
      ram_we_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      blocked_q   <= blocked_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ram_we_q    <= ram_we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_done   = done0_q;
  assign m1_done   = done1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m1_err    = err_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = cmd_addr_q;
  assign ram_wdata = cmd_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions plus contention,
// request-drop and mid-access reset sequences against a behavioural 256x8 RAM.
module tb_mem_arbiter;

`ifdef MEM_ARB_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_req = 1'b0, m0_we = 1'b0;
  logic [7:0] m0_addr = 8'h00, m0_wdata = 8'h00;
  logic       m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0] m1_addr = 8'h00, m1_wdata = 8'h00;
  logic       m0_gnt, m0_done, m1_gnt, m1_done, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_we, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_ramwe;
    logic       exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    tick();
    chk("gnt_owner", 8'(v.port ? m1_gnt : m0_gnt), 8'h01);
    chk("gnt_other", 8'(v.port ? m0_gnt : m1_gnt), 8'h00);
    chk("ram_we_access", 8'(ram_we), 8'(v.exp_ramwe));
    chk("ram_addr_access", ram_addr, v.addr);
    chk("busy_access", 8'(busy), 8'h01);
    tick();
    drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("done_owner", 8'(v.port ? m1_done : m0_done), 8'h01);
    chk("done_other", 8'(v.port ? m0_done : m1_done), 8'h00);
    chk("rdata", v.port ? m1_rdata : m0_rdata, v.exp_rdata);
    chk("m1_err", 8'(m1_err), 8'(v.exp_err));
    chk("ram_we_done", 8'(ram_we), 8'h00);
    tick();
    chk("done_clear", 8'({m0_done, m1_done}), 8'h00);
    chk("busy_idle", 8'(busy), 8'h00);
  endtask

  initial begin
    logic order [$];
    logic last_owner;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    // port, we, addr, wdata, exp_rdata (pre-write byte on writes), exp ram_we, exp err
    vecs[0] = '{1'b0, 1'b1, 8'h20, 8'hA5, 8'h7A, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 8'hFF, 8'h4A, !WP, WP};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, WP ? 8'h4A : 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h40, 8'h3C, 8'h1A, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h40, 8'h00, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h10, 8'h11, WP ? 8'h4A : 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'h3F, 8'h77, 8'h65, !WP, WP};
    vecs[9] = '{1'b1, 1'b0, 8'h3F, 8'h00, WP ? 8'h65 : 8'h77, 1'b0, 1'b0};

    #2;
    chk("rst_outputs", 8'({m0_gnt, m0_done, m1_gnt, m1_done, m1_err, ram_we, busy}), 8'h00);
    chk("rst_ram_addr", ram_addr, 8'h00);
    chk("rst_ram_wdata", ram_wdata, 8'h00);
    chk("rst_rdata", m0_rdata | m1_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("mem_10", mem[8'h10], 8'h11);

    // Continuous contention from reset: grants alternate m0, m1, m0, m1.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    last_owner = 1'b0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (m0_gnt || m1_gnt) begin
        order.push_back(m1_gnt);
        last_owner = m1_gnt;
      end
      if (m0_done || m1_done) begin
        chk("done_to_owner", 8'({m0_done, m1_done}), last_owner ? 8'h01 : 8'h02);
        chk("contend_rdata", last_owner ? m1_rdata : m0_rdata, last_owner ? 8'h3C : 8'hA5);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("grant_count", 8'(order.size()), 8'h04);
    for (int k = 0; k < order.size() && k < 4; k++)
      chk("grant_order", 8'(order[k]), 8'(k % 2));
    tick();
    tick();
    chk("busy_after_contend", 8'({busy, m0_gnt, m1_gnt}), 8'h00);

    // m1 drops req during ACCESS: one done, no second transaction.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    chk("drop_gnt", 8'(m1_gnt), 8'h01);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("drop_done", 8'(m1_done), 8'h01);
    chk("drop_rdata", m1_rdata, 8'h3C);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("drop_quiet", 8'({busy, m1_gnt, m1_done, m0_gnt, m0_done}), 8'h00);
    end

    // Reset asserted mid-ACCESS of a write: immediate clear, no commit, no done.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h99);
    tick();
    chk("mid_ram_we", 8'(ram_we), 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_outs", 8'({m0_gnt, m0_done, m1_gnt, m1_done, m1_err, ram_we, busy}), 8'h00);
    chk("mid_rst_addr", ram_addr, 8'h00);
    chk("mid_rst_rdata", m0_rdata, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("mid_no_done", 8'(m0_done), 8'h00);
    chk("mid_no_write", mem[8'h50], 8'h0A);
    @(negedge clk);
    rst = 1'b0;

    // First tie after reset goes to port 0.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h50, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    chk("tie_gnt", 8'({m0_gnt, m1_gnt}), 8'h02);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("tie_done", 8'({m0_done, m1_done}), 8'h02);
    chk("tie_rdata", m0_rdata, 8'h0A);
    tick();
    tick();
    chk("tie_quiet", 8'({busy, m1_gnt}), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the shared 256×8 data RAM's read/write port (write enable, write/read address, write data, read-back data). It sits between the RAM and two masters: port 0 (CPU load/store unit) and port 1 (program loader / debug). It serialises their single-byte reads and writes under round-robin priority and returns read data with a one-cycle done pulse. The RAM's instruction-fetch read port is not touched by this block.

## Interface
Parameters:
- WP_LO, 8'h00, lowest address of the port-1 write-protected window (inclusive)
- WP_HI, 8'h3F, highest address of the port-1 write-protected window (inclusive)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 request; held high with command stable until m0_done
- m0_we  in  1  port 0: 1 = write, 0 = read
- m0_addr  in  8  port 0 byte address
- m0_wdata  in  8  port 0 write data
- m0_gnt  out  1  port 0 owns the RAM this cycle (ACCESS state)
- m0_done  out  1  one-cycle pulse: port 0 transaction complete
- m0_rdata  out  8  port 0 read data, valid while m0_done is high
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as port 0, for port 1
- m1_err  out  1  one-cycle pulse with m1_done when a port-1 write was suppressed
- ram_we  out  1  RAM write enable
- ram_addr  out  8  RAM read/write address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM asynchronous read data at ram_addr
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req high, select winner, latch its we/addr/wdata into cmd registers, record owner, -> ACCESS. Else stay.
- Arbitration: one requester -> it wins. Both -> the port not served last wins (last_served flag updated on every grant).
- ACCESS (exactly 1 cycle): ram_addr = latched addr; ram_wdata = latched wdata; ram_we = latched we (gated per Configuration); owner's gnt = 1. At the closing edge, ram_rdata is captured into the owner's rdata register (also on writes; value then is the pre-write byte). -> DONE.
- DONE (1 cycle): owner's done = 1 (registered output), err per Configuration. -> IDLE.
- Requests are sampled only in IDLE. Req dropped during ACCESS/DONE: transaction still completes and done still pulses. Req still high in the IDLE cycle after done is a new request.
- Outside ACCESS: ram_we = 0; ram_addr/ram_wdata hold latched values.
- rdata registers hold last captured value until next capture for that port.

## Timing
- Reset (async, immediate): state IDLE; ram_we, ram_addr, ram_wdata, all gnt/done/err, busy = 0; m0_rdata = m1_rdata = 8'h00; last_served = port 1 (port 0 wins the first tie). Reset mid-ACCESS aborts the write only if rst asserts before the write edge; no done is issued.
- Latency: req high at edge E0 (state IDLE) -> gnt during cycle E0..E1 -> write commits / read captured at E1 -> done high E1..E2 -> IDLE at E2.
- Throughput: one transaction per 3 cycles; under continuous contention ports alternate.
- rdata valid from the edge done rises; requester must sample it while done is high.

## Configuration
- Macro MEM_ARB_WP_EN.
- Defined: port-1 write with WP_LO <= addr <= WP_HI runs the normal FSM sequence but ram_we stays 0 in ACCESS; m1_err pulses with m1_done. Port-1 reads and all port-0 accesses unaffected.
- Undefined: no protection, all writes reach the RAM, m1_err tied 0 (port still present).

## Test plan
- Reset then m0 write addr 8'h20 data 8'hA5 -> ram_we high exactly one cycle with ram_addr 8'h20, m0_done one cycle 2 edges after request; m0 read 8'h20 -> m0_rdata = 8'hA5 with m0_done.
- m0 and m1 both request from IDLE after reset, held continuously -> grants order m0, m1, m0, m1; each done pulse goes only to its owner; busy drops only when both deassert.
- m1 drops req during ACCESS -> m1_done still pulses once, no second transaction started.
- With MEM_ARB_WP_EN: m1 write 8'h10 <- 8'hFF -> ram_we never high, m1_err and m1_done pulse together, later read of 8'h10 unchanged; m1 write 8'h40 succeeds with m1_err = 0. Without macro: write to 8'h10 lands, m1_err stays 0.
- rst asserted asynchronously mid-ACCESS of a write -> all outputs 0 immediately, no done, next tie goes to port 0.
